dtw_ref_multiport: RTL and testbench
====================================

DTW_REF_MULTIPORT -- requirements
Module: dtw_ref_multiport

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, reference sample width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of ref_len_in and load_count_out.
REQ-003 SHALL have parameter REFMEM_PTR_WIDTH, default 10, memory address width; depth = 2^REFMEM_PTR_WIDTH words.
REQ-004 SHALL have parameter NUM_PORTS, default 4, number of independent read ports (1..16).
REQ-005 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rs_in  input  1  run (1) / stop (0).
REQ-008 SHALL have port op_mode_in  input  1  0 = DTW read, 1 = load reference.
REQ-009 SHALL have port ref_len_in  input  ADDR_WIDTH  number of words to load.
REQ-010 SHALL have port busy_out  output  1  high in LOAD or READ.
REQ-011 SHALL have port ref_load_done_out  output  1  a complete reference is resident.
REQ-012 SHALL have port load_err_out  output  1  last load request was rejected.
REQ-013 SHALL have port load_count_out  output  ADDR_WIDTH  words written by the current/last load.
REQ-014 SHALL have port src_fifo_clear_out  output  1  source FIFO clear.
REQ-015 SHALL have port src_fifo_rden_out  output  1  source FIFO read enable.
REQ-016 SHALL have port src_fifo_empty_in  input  1  source FIFO empty.
REQ-017 SHALL have port src_fifo_data_in  input  DATA_WIDTH  source FIFO data, first-word-fall-through.
REQ-018 SHALL have port ref_addr_in  input  NUM_PORTS*REFMEM_PTR_WIDTH  read addresses; port p at slice p.
REQ-019 SHALL have port ref_data_out  output  NUM_PORTS*DATA_WIDTH  read data; port p at slice p.
REQ-020 SHALL have port dbg_state  output  2  FSM state encoding.

Function
REQ-021 SHALL implement states IDLE=0, LOAD=1, READ=2; encoding 3 SHALL return to IDLE on the next clock.
REQ-022 In IDLE: busy_out=0, src_fifo_rden_out=0, src_fifo_clear_out=1; in LOAD and READ src_fifo_clear_out=0.
REQ-023 IDLE with rs_in=1, op_mode_in=1, and 1 <= ref_len_in <= 2^REFMEM_PTR_WIDTH: latch ref_len_in, zero load_count_out, clear ref_load_done_out and load_err_out, and enter LOAD.
REQ-024 IDLE with rs_in=1, op_mode_in=1, and ref_len_in==0 or ref_len_in > depth: set load_err_out=1, stay in IDLE, and leave ref_load_done_out unchanged.
REQ-025 IDLE with rs_in=1 and op_mode_in=0: enter READ only when ref_load_done_out=1, else stay in IDLE.
REQ-026 LOAD: src_fifo_rden_out=1 while count < latched length, else 0 (combinational from state and count).
REQ-027 LOAD: a word is accepted in a cycle with src_fifo_rden_out=1 and src_fifo_empty_in=0.
REQ-028 LOAD: an accepted word is written to memory at address count, then count increments; no write or increment when empty.
REQ-029 LOAD: the cycle that accepts word number length-1 SHALL set ref_load_done_out=1 and return to IDLE on the next edge.
REQ-030 LOAD: rs_in=0 aborts the load: next state IDLE, ref_load_done_out stays 0, load_count_out holds the partial count, and no write occurs in the abort cycle.
REQ-031 READ: stay while rs_in=1 and op_mode_in=0; otherwise return to IDLE (no direct READ->LOAD transition).
REQ-032 Each read port p SHALL return mem[ref_addr_in[p]] on ref_data_out[p] exactly one clock after the address, in every state.
REQ-033 Read during a same-address write SHALL return the old data (read-first).
REQ-034 Ports SHALL be fully independent; simultaneous identical addresses on any ports SHALL return identical data.
REQ-035 Memory contents SHALL NOT be cleared by reset or abort; content after reset is undefined.

Reset
REQ-036 rst_in=1 at any edge, including mid-load, SHALL force: state IDLE, busy_out=0, src_fifo_rden_out=0, src_fifo_clear_out=1, ref_load_done_out=0, load_err_out=0, load_count_out=0.
REQ-037 ref_data_out SHALL be unaffected by reset (it continues to reflect registered memory reads).

Verification
REQ-038 Load len=8 with FIFO holding 0x10..0x17, rs=1, mode=1 -> 8 writes, done=1 after the 8th accept, count=8, then IDLE with clear=1.
REQ-039 Load len=4 with empty toggling every other cycle -> writes only on non-empty cycles, addresses 0..3 contiguous, done=1 after 4 accepts.
REQ-040 After a load, mode=0, rs=1, ports 0..3 addressed 3,0,3,7 -> next cycle data = mem[3], mem[0], mem[3], mem[7]; busy=1.
REQ-041 Request len=0 and len=depth+1 -> err=1, state stays IDLE, done unchanged; mode=0, rs=1 with done=0 -> stays IDLE.
REQ-042 Abort (rs=0) after 3 of 8 words -> IDLE, done=0, count=3; rst_in mid-load -> all REQ-036 values on the next cycle.
REQ-043 During LOAD, a read port addressing the current write address -> returns the pre-write value; on the following cycle, the new value.

Source files
------------

// File: rtl/dtw_ref_multiport.sv
// -----------------------------------------------------------------------------
// dtw_ref_multiport
//
// Reference-sequence store for a DTW engine. A reference of up to
// 2^REFMEM_PTR_WIDTH samples is streamed in from a first-word-fall-through
// source FIFO (LOAD), after which NUM_PORTS independent read ports serve it
// to the DTW datapath (READ). Every read port is a registered memory read
// with one clock of latency and read-first behaviour, active in all states.
//
// Ports
//   clk_in              single clock, all logic on the rising edge
//   rst_in              synchronous active-high reset
//   rs_in               run (1) / stop (0)
//   op_mode_in          0 = DTW read, 1 = load reference
//   ref_len_in          number of words to load (1 .. depth)
//   busy_out            high while in LOAD or READ
//   ref_load_done_out   a complete reference is resident
//   load_err_out        last load request was rejected (bad length)
//   load_count_out      words written by the current / last load
//   src_fifo_clear_out  source FIFO clear (held while IDLE)
//   src_fifo_rden_out   source FIFO read enable
//   src_fifo_empty_in   source FIFO empty
//   src_fifo_data_in    source FIFO head word (FWFT)
//   ref_addr_in         packed read addresses, port p at slice p
//   ref_data_out        packed read data, port p at slice p
//   dbg_state           FSM state encoding (IDLE=0, LOAD=1, READ=2)
// -----------------------------------------------------------------------------
module dtw_ref_multiport #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 32,
    parameter int REFMEM_PTR_WIDTH = 10,
    parameter int NUM_PORTS        = 4
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   rs_in,
    input  logic                                   op_mode_in,
    input  logic [ADDR_WIDTH-1:0]                  ref_len_in,
    output logic                                   busy_out,
    output logic                                   ref_load_done_out,
    output logic                                   load_err_out,
    output logic [ADDR_WIDTH-1:0]                  load_count_out,
    output logic                                   src_fifo_clear_out,
    output logic                                   src_fifo_rden_out,
    input  logic                                   src_fifo_empty_in,
    input  logic [DATA_WIDTH-1:0]                  src_fifo_data_in,
    input  logic [NUM_PORTS*REFMEM_PTR_WIDTH-1:0]  ref_addr_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]        ref_data_out,
    output logic [1:0]                             dbg_state
);

    localparam int                    DEPTH   = 1 << REFMEM_PTR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   len_q, len_next;
    logic [ADDR_WIDTH-1:0]   count_q, count_next;
    logic                    done_q, done_next;
    logic                    err_q, err_next;
    logic                    mem_we;
    logic                    len_ok;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // A load request is only legal for 1 .. depth words.
    assign len_ok = (ref_len_in != '0) && (ref_len_in <= DEPTH_A);

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case statement can leave one unassigned (no latches).
        state_next         = state;
        len_next           = len_q;
        count_next         = count_q;
        done_next          = done_q;
        err_next           = err_q;
        mem_we             = 1'b0;
        busy_out           = 1'b0;
        src_fifo_rden_out  = 1'b0;
        src_fifo_clear_out = 1'b0;

        case (state)
            ST_IDLE: begin
                src_fifo_clear_out = 1'b1;
                if (rs_in) begin
                    if (op_mode_in) begin
                        if (len_ok) begin
                            len_next   = ref_len_in;
                            count_next = '0;
                            done_next  = 1'b0;
                            err_next   = 1'b0;
                            state_next = ST_LOAD;
                        end else begin
                            // Rejected request: the resident reference, if
                            // any, stays valid.
                            err_next = 1'b1;
                        end
                    end else if (done_q) begin
                        state_next = ST_READ;
                    end
                end
            end

            ST_LOAD: begin
                busy_out          = 1'b1;
                src_fifo_rden_out = (count_q < len_q);
                if (!rs_in) begin
                    // Abort: keep the partial count, no write this cycle.
                    state_next = ST_IDLE;
                end else if (src_fifo_rden_out && !src_fifo_empty_in) begin
                    mem_we     = 1'b1;
                    count_next = count_q + ONE_A;
                    if (count_q == len_q - ONE_A) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_READ: begin
                busy_out = 1'b1;
                // Any change of mode or a stop drops back to IDLE; a new
                // load always starts from IDLE.
                if (!(rs_in && !op_mode_in)) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                // Unused encoding 3: behave as IDLE and recover next clock.
                src_fifo_clear_out = 1'b1;
                state_next         = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_in) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            len_q   <= len_next;
            count_q <= count_next;
            done_q  <= done_next;
            err_q   <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Reference memory: one write port, NUM_PORTS registered read ports
    // -------------------------------------------------------------------------
    // NOTE: the memory array and its read registers have no reset; contents
    // survive reset and aborts, which also lets the array map onto RAM.
    always_ff @(posedge clk_in) begin
        if (mem_we && !rst_in) begin
            mem[count_q[REFMEM_PTR_WIDTH-1:0]] <= src_fifo_data_in;
        end
    end

    // Reads sample the array before this edge's write lands, which gives
    // read-first behaviour on a same-address collision.
    always_ff @(posedge clk_in) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            ref_data_out[p*DATA_WIDTH +: DATA_WIDTH] <=
                mem[ref_addr_in[p*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH]];
        end
    end

    assign ref_load_done_out = done_q;
    assign load_err_out      = err_q;
    assign load_count_out    = count_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_dtw_ref_multiport.sv
// -----------------------------------------------------------------------------
// Testbench for dtw_ref_multiport (default parameters: 16-bit data, depth
// 1024, 4 read ports). A behavioural source FIFO feeds the load path; a
// memory model plus a read scoreboard predicts every read-port result, which
// is pushed when the address is driven and popped one clock later.
// -----------------------------------------------------------------------------
module tb_dtw_ref_multiport;

    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int PW    = 10;
    localparam int NP    = 4;
    localparam int DEPTH = 1 << PW;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              rs_in = 1'b0;
    logic              op_mode_in = 1'b0;
    logic [AW-1:0]     ref_len_in = '0;
    logic              busy_out;
    logic              ref_load_done_out;
    logic              load_err_out;
    logic [AW-1:0]     load_count_out;
    logic              src_fifo_clear_out;
    logic              src_fifo_rden_out;
    logic              src_fifo_empty_in = 1'b1;
    logic [DW-1:0]     src_fifo_data_in = '0;
    logic [NP*PW-1:0]  ref_addr_in = '0;
    logic [NP*DW-1:0]  ref_data_out;
    logic [1:0]        dbg_state;

    dtw_ref_multiport dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rs_in              (rs_in),
        .op_mode_in         (op_mode_in),
        .ref_len_in         (ref_len_in),
        .busy_out           (busy_out),
        .ref_load_done_out  (ref_load_done_out),
        .load_err_out       (load_err_out),
        .load_count_out     (load_count_out),
        .src_fifo_clear_out (src_fifo_clear_out),
        .src_fifo_rden_out  (src_fifo_rden_out),
        .src_fifo_empty_in  (src_fifo_empty_in),
        .src_fifo_data_in   (src_fifo_data_in),
        .ref_addr_in        (ref_addr_in),
        .ref_data_out       (ref_data_out),
        .dbg_state          (dbg_state)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            port;
        logic [DW-1:0] exp;
    } sb_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] src_q[$];
    bit            gate_empty = 1'b0;
    logic [DW-1:0] mem_model [DEPTH];
    bit            known [DEPTH];
    int            wr_ptr = 0;
    sb_t           sb[$];
    logic [PW-1:0] addr [NP];

    task automatic drive_pins();
        src_fifo_empty_in = gate_empty || (src_q.size() == 0);
        src_fifo_data_in  = (src_q.size() > 0) ? src_q[0] : '0;
        for (int p = 0; p < NP; p++) ref_addr_in[p*PW +: PW] = addr[p];
    endtask

    // One clock: predict reads and writes from pre-edge inputs, advance past
    // the rising edge, then drain the read scoreboard on the falling edge.
    task automatic tick();
        bit  pop;
        bit  wr;
        sb_t e;
        logic [DW-1:0] got;
        drive_pins();
        #1;
        pop = src_fifo_rden_out && !src_fifo_empty_in;
        wr  = pop && rs_in && !rst_in;
        for (int p = 0; p < NP; p++) begin
            if (known[addr[p]]) sb.push_back('{p, mem_model[addr[p]]});
        end
        if (pop && rst_in) known[wr_ptr] = 1'b0;
        if (wr) begin
            mem_model[wr_ptr] = src_q[0];
            known[wr_ptr]     = 1'b1;
            wr_ptr++;
        end
        if (pop) void'(src_q.pop_front());
        @(posedge clk_in);
        @(negedge clk_in);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = ref_data_out[e.port*DW +: DW];
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL rd_port%0d got %h expected %h", e.port, got, e.exp);
            end
        end
    endtask

    task automatic start_load(input int len);
        ref_len_in = AW'(len);
        op_mode_in = 1'b1;
        rs_in      = 1'b1;
        wr_ptr     = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d expected 0", dbg_state); end
        n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy_out); end
        n_checks++; if (src_fifo_rden_out !== 1'b0) begin n_fail++; $display("FAIL reset_rden got %b expected 0", src_fifo_rden_out); end
        n_checks++; if (src_fifo_clear_out !== 1'b1) begin n_fail++; $display("FAIL reset_clear got %b expected 1", src_fifo_clear_out); end
        n_checks++; if (ref_load_done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", ref_load_done_out); end
        n_checks++; if (load_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", load_err_out); end
        n_checks++; if (load_count_out !== '0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", load_count_out); end
        rst_in = 1'b0;
    endtask

    task automatic test_load_basic();
        int cycles = 0;
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(16'h10 + i));
        gate_empty = 1'b0;
        start_load(8);
        n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL load_enter got %0d expected 1", dbg_state); end
        n_checks++; if (busy_out !== 1'b1 || src_fifo_clear_out !== 1'b0 || src_fifo_rden_out !== 1'b1) begin
            n_fail++; $display("FAIL load_flags got busy=%b clear=%b rden=%b expected 1 0 1", busy_out, src_fifo_clear_out, src_fifo_rden_out);
        end
        while (!ref_load_done_out && cycles < 20) begin
            tick();
            cycles++;
        end
        rs_in = 1'b0;
        n_checks++; if (cycles !== 8) begin n_fail++; $display("FAIL load_cycles got %0d expected 8", cycles); end
        n_checks++; if (load_count_out !== 32'd8) begin n_fail++; $display("FAIL load_count got %0d expected 8", load_count_out); end
        n_checks++; if (dbg_state !== 2'd0 || src_fifo_clear_out !== 1'b1 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL load_exit got state=%0d clear=%b busy=%b expected 0 1 0", dbg_state, src_fifo_clear_out, busy_out);
        end
        n_checks++; if (src_q.size() !== 0) begin n_fail++; $display("FAIL load_fifo_drained got %0d expected 0", src_q.size()); end
    endtask

    task automatic test_read_ports();
        addr[0] = 10'd3; addr[1] = 10'd0; addr[2] = 10'd3; addr[3] = 10'd7;
        op_mode_in = 1'b0;
        rs_in      = 1'b1;
        tick();
        n_checks++; if (ref_data_out !== {16'h17, 16'h13, 16'h10, 16'h13}) begin
            n_fail++; $display("FAIL read_3037 got %h expected 0017001300100013", ref_data_out);
        end
        n_checks++; if (dbg_state !== 2'd2 || busy_out !== 1'b1) begin
            n_fail++; $display("FAIL read_enter got state=%0d busy=%b expected 2 1", dbg_state, busy_out);
        end
        addr[0] = 10'd1; addr[1] = 10'd2; addr[2] = 10'd5; addr[3] = 10'd6;
        tick();
        for (int p = 0; p < NP; p++) addr[p] = 10'd4;
        tick();
        n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL read_hold got busy=%b expected 1", busy_out); end
        rs_in = 1'b0;
        tick();
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL read_exit got %0d expected 0", dbg_state); end
    endtask

    task automatic test_load_gaps();
        int cycles = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(DW'(16'hA0 + i));
        start_load(4);
        gate_empty = 1'b1;
        while (!ref_load_done_out && cycles < 20) begin
            tick();
            cycles++;
            gate_empty = !gate_empty;
            n_checks++; if (load_count_out !== AW'(cycles / 2)) begin
                n_fail++; $display("FAIL gap_count cycle %0d got %0d expected %0d", cycles, load_count_out, cycles / 2);
            end
        end
        rs_in      = 1'b0;
        gate_empty = 1'b0;
        n_checks++; if (cycles !== 8) begin n_fail++; $display("FAIL gap_cycles got %0d expected 8", cycles); end
        n_checks++; if (ref_load_done_out !== 1'b1) begin n_fail++; $display("FAIL gap_done got %b expected 1", ref_load_done_out); end
        for (int p = 0; p < NP; p++) addr[p] = PW'(p);
        tick();
        n_checks++; if (ref_data_out !== {16'hA3, 16'hA2, 16'hA1, 16'hA0}) begin
            n_fail++; $display("FAIL gap_contig got %h expected 00a300a200a100a0", ref_data_out);
        end
        for (int p = 0; p < NP; p++) addr[p] = PW'(p + 4);
        tick();
    endtask

    task automatic test_bad_len();
        rs_in = 1'b1; op_mode_in = 1'b1; ref_len_in = 32'd0;
        tick();
        rs_in = 1'b0;
        n_checks++; if (load_err_out !== 1'b1 || dbg_state !== 2'd0 || ref_load_done_out !== 1'b1) begin
            n_fail++; $display("FAIL len0 got err=%b state=%0d done=%b expected 1 0 1", load_err_out, dbg_state, ref_load_done_out);
        end
        tick();
        rs_in = 1'b1; ref_len_in = 32'(DEPTH + 1);
        tick();
        rs_in = 1'b0;
        n_checks++; if (load_err_out !== 1'b1 || dbg_state !== 2'd0 || ref_load_done_out !== 1'b1) begin
            n_fail++; $display("FAIL len_over got err=%b state=%0d done=%b expected 1 0 1", load_err_out, dbg_state, ref_load_done_out);
        end
        // Exactly depth is legal; abort it at once with nothing loaded.
        start_load(DEPTH);
        n_checks++; if (dbg_state !== 2'd1 || load_err_out !== 1'b0 || ref_load_done_out !== 1'b0) begin
            n_fail++; $display("FAIL len_depth got state=%0d err=%b done=%b expected 1 0 0", dbg_state, load_err_out, ref_load_done_out);
        end
        rs_in = 1'b0;
        tick();
        rs_in = 1'b1; op_mode_in = 1'b0;
        tick();
        n_checks++; if (dbg_state !== 2'd0 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL read_no_ref got state=%0d busy=%b expected 0 0", dbg_state, busy_out);
        end
        rs_in = 1'b0;
    endtask

    task automatic test_abort_and_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(16'h30 + i));
        start_load(8);
        repeat (3) tick();
        rs_in = 1'b0;
        tick();
        n_checks++; if (dbg_state !== 2'd0 || ref_load_done_out !== 1'b0 || load_count_out !== 32'd3) begin
            n_fail++; $display("FAIL abort got state=%0d done=%b count=%0d expected 0 0 3", dbg_state, ref_load_done_out, load_count_out);
        end
        src_q.delete();
        for (int p = 0; p < NP; p++) addr[p] = PW'(p);
        tick();
        n_checks++; if (ref_data_out !== {16'hA3, 16'h32, 16'h31, 16'h30}) begin
            n_fail++; $display("FAIL abort_mem got %h expected 00a3003200310030", ref_data_out);
        end
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(16'h40 + i));
        start_load(8);
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
        n_checks++; if (dbg_state !== 2'd0 || busy_out !== 1'b0 || src_fifo_rden_out !== 1'b0 || src_fifo_clear_out !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_ctl got state=%0d busy=%b rden=%b clear=%b expected 0 0 0 1", dbg_state, busy_out, src_fifo_rden_out, src_fifo_clear_out);
        end
        n_checks++; if (ref_load_done_out !== 1'b0 || load_err_out !== 1'b0 || load_count_out !== '0) begin
            n_fail++; $display("FAIL rst_mid_regs got done=%b err=%b count=%0d expected 0 0 0", ref_load_done_out, load_err_out, load_count_out);
        end
        rst_in = 1'b0;
        rs_in  = 1'b0;
        src_q.delete();
        tick();
    endtask

    task automatic test_rw_collision();
        src_q.push_back(16'h0055);
        src_q.push_back(16'h0066);
        start_load(2);
        addr[0] = 10'd0; addr[1] = 10'd1; addr[2] = 10'd0; addr[3] = 10'd5;
        tick();
        n_checks++; if (ref_data_out[15:0] !== 16'h0040) begin
            n_fail++; $display("FAIL collide_old got %h expected 0040", ref_data_out[15:0]);
        end
        tick();
        n_checks++; if (ref_data_out[15:0] !== 16'h0055 || ref_data_out[31:16] !== 16'h0041) begin
            n_fail++; $display("FAIL collide_next got %h %h expected 0055 0041", ref_data_out[15:0], ref_data_out[31:16]);
        end
        rs_in = 1'b0;
        n_checks++; if (ref_load_done_out !== 1'b1 || load_count_out !== 32'd2) begin
            n_fail++; $display("FAIL collide_done got done=%b count=%0d expected 1 2", ref_load_done_out, load_count_out);
        end
        tick();
    endtask

    initial begin
        for (int p = 0; p < NP; p++) addr[p] = '0;
        test_reset();
        test_load_basic();
        test_read_ports();
        test_load_gaps();
        test_bad_len();
        test_abort_and_reset();
        test_rw_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got no completion expected finish");
        $fatal(1);
    end

endmodule
